encoder_4x2_seq: RTL and testbench

ENCODER_4X2_SEQ -- requirements
Module: encoder_4x2_seq

---
 rtl/encoder_4x2_seq_pkg.sv | 8 +
 rtl/encoder_4x2_seq_pick.sv | 27 ++
 rtl/encoder_4x2_seq.sv | 53 +++++
 tb/tb_encoder_4x2_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/encoder_4x2_seq_pkg.sv
// enc_pkg: shared sizes, FSM state type and pointer reset value for encoder_4x2_seq
package enc_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] RR_PTR_RST = 2'd3;
  localparam logic [IDX_W-1:0] FIX_BASE = 2'd3;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/encoder_4x2_seq_pick.sv
// enc_pick: combinational request selector; pend/base in, idx/found out; ENC_ROUND_ROBIN_EN searches upward from base+1, otherwise downward from base
module enc_pick
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W-1:0] w_c;
  always_comb begin
    idx = '0;
    found = 1'b0;
    w_c = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ENC_ROUND_ROBIN_EN
      w_c = base + IDX_W'(k + 1);
`else
      w_c = base - IDX_W'(k);
`endif
      if (pend[w_c]) begin
        idx = w_c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encoder_4x2_seq.sv
// encoder_4x2_seq: sticky 4-request encoder with valid/ready handshake; in d0-d3, ready; out q1/q0 code, valid, busy; ENC_ROUND_ROBIN_EN selects round-robin
module encoder_4x2_seq
  import enc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic ready,
  output logic q1,
  output logic q0,
  output logic valid,
  output logic busy
);
  logic [N_REQ-1:0] r_pend, w_d, w_clr, w_pend_nxt;
  logic [IDX_W-1:0] r_q, w_idx, w_base;
  logic r_valid, w_found, w_load;
  state_t r_state, w_state_nxt;
  assign w_d = {d3, d2, d1, d0};
`ifdef ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  assign w_base = r_ptr;
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= RR_PTR_RST;
    else if (w_load) r_ptr <= w_idx;
`else
  assign w_base = FIX_BASE;
`endif
  enc_pick u_pick (.pend(r_pend), .base(w_base), .idx(w_idx), .found(w_found));
  always_comb begin
    w_load = w_found && (r_state == IDLE || ready);
    w_state_nxt = w_load ? HOLD : (ready ? IDLE : r_state);
  end
  // a fresh request on the bit being cleared survives: set is OR-ed after the clear
  assign w_clr = w_load ? N_REQ'(1) << w_idx : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_d;
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_state_nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pend <= '0;
      r_q <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_valid <= w_state_nxt == HOLD;
      if (w_load) r_q <= w_idx;
    end
  assign {q1, q0} = r_q;
  assign valid = r_valid;
  assign busy = r_valid | (|r_pend);
endmodule

// File: tb/tb_encoder_4x2_seq.sv
// tb_encoder_4x2_seq: scoreboard bench for encoder_4x2_seq
module tb_encoder_4x2_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b0;
  logic [3:0] d = 4'b0;
  logic q1, q0, valid, busy;
  int n_vec = 0;
  int n_err = 0;
  int n;
  logic [1:0] sb[$];
`ifdef ENC_ROUND_ROBIN_EN
  logic [1:0] burst_exp[3] = '{2'd0, 2'd1, 2'd3};
  logic [1:0] bp_exp[2] = '{2'd1, 2'd2};
  logic [1:0] all_exp[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] all_rst = 2'd0;
`else
  logic [1:0] burst_exp[3] = '{2'd3, 2'd1, 2'd0};
  logic [1:0] bp_exp[2] = '{2'd2, 2'd1};
  logic [1:0] all_exp[5] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [1:0] all_rst = 2'd3;
`endif
  encoder_4x2_seq dut (
    .clk(clk), .rst_n(rst_n), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .ready(ready), .q1(q1), .q0(q0), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) cyc();
    rst_n = 1'b1;
  endtask
  task automatic drain(input int budget, output int cnt);
    cnt = 0;
    while (sb.size() != 0 && cnt < budget) begin
      cyc();
      cnt++;
    end
    chk("drain_left", 8'(sb.size()), 8'd0);
  endtask
  always @(negedge clk)
    if (rst_n && valid && ready) begin
      chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) chk("code", 8'({q1, q0}), 8'(sb.pop_front()));
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      d = 4'b1111;
      cyc();
      chk("rst_valid", 8'(valid), 8'd0);
      chk("rst_q", 8'({q1, q0}), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
    end
    rst_n = 1'b1;
    d = 4'b0;
    cyc();
    chk("idle_busy", 8'(busy), 8'd0);
    ready = 1'b1;
    d = 4'b0100;
    sb.push_back(2'd2);
    cyc();
    d = 4'b0;
    chk("s_lat", 8'(valid), 8'd0);
    chk("s_busy", 8'(busy), 8'd1);
    cyc();
    chk("s_valid", 8'(valid), 8'd1);
    chk("s_q", 8'({q1, q0}), 8'd2);
    cyc();
    chk("s_done", 8'(valid), 8'd0);
    chk("s_idle", 8'(busy), 8'd0);
    chk("s_drain", 8'(sb.size()), 8'd0);
    do_reset(2);
    ready = 1'b1;
    d = 4'b1011;
    foreach (burst_exp[i]) sb.push_back(burst_exp[i]);
    cyc();
    d = 4'b0;
    drain(20, n);
    chk("burst_cycles", 8'(n), 8'd4);
    chk("burst_end", 8'(valid), 8'd0);
    do_reset(2);
    ready = 1'b0;
    d = 4'b0110;
    foreach (bp_exp[i]) sb.push_back(bp_exp[i]);
    cyc();
    d = 4'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 8'(valid), 8'd1);
      chk("bp_q", 8'({q1, q0}), 8'(bp_exp[0]));
      cyc();
    end
    ready = 1'b1;
    drain(20, n);
    chk("bp_cycles", 8'(n), 8'd2);
    chk("bp_end", 8'(valid), 8'd0);
    do_reset(2);
    ready = 1'b1;
    d = 4'b0010;
    repeat (8) sb.push_back(2'd1);
    cyc();
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("sbc_valid", 8'(valid), 8'd1);
      cyc();
    end
    ready = 1'b0;
    d = 4'b0;
    chk("sbc_drain", 8'(sb.size()), 8'd0);
    do_reset(2);
    ready = 1'b1;
    d = 4'b1111;
    foreach (all_exp[i]) sb.push_back(all_exp[i]);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("all_valid", 8'(valid), 8'd1);
      cyc();
    end
    chk("all_drain", 8'(sb.size()), 8'd0);
    rst_n = 1'b0;
    cyc();
    chk("mr_valid", 8'(valid), 8'd0);
    chk("mr_q", 8'({q1, q0}), 8'd0);
    chk("mr_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    sb.push_back(all_rst);
    cyc();
    chk("mr_lat", 8'(valid), 8'd0);
    chk("mr_pend", 8'(busy), 8'd1);
    cyc();
    chk("mr_valid2", 8'(valid), 8'd1);
    cyc();
    ready = 1'b0;
    d = 4'b0;
    chk("mr_drain", 8'(sb.size()), 8'd0);
    do_reset(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
